bpsk_sample_gen: RTL and testbench

Upstream stage of the delta-sigma DAC. Accepts data bytes over a valid/ready handshake and serialises them MSB-first into BPSK symbols. Each symbol is a whole number of sine carrier periods, polarity set by the bit. Emits an 8-bit offset-binary sample stream, held between sample strobes, that drives the DAC's 8-bit input directly.

---
 rtl/bpsk_pkg.sv | 21 ++
 rtl/bpsk_sine_rom.sv | 16 +
 rtl/bpsk_sample_gen.sv | 161 ++++++++++++++++
 tb/tb_bpsk_sample_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared constants and types for the BPSK sample generator and related blocks.
package bpsk_pkg;

  localparam int unsigned LUT_DEPTH  = 32;
  localparam int unsigned PHASE_W    = $clog2(LUT_DEPTH);
  localparam logic [7:0]  IDLE_LEVEL = 8'd128;

  // One carrier period, round(128 + 127*sin(2*pi*k/32)), offset binary.
  localparam logic [7:0] SINE_LUT [LUT_DEPTH] = '{
    8'd128, 8'd153, 8'd177, 8'd199, 8'd218, 8'd234, 8'd245, 8'd253,
    8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd199, 8'd177, 8'd153,
    8'd128, 8'd103, 8'd79,  8'd57,  8'd38,  8'd22,  8'd11,  8'd3,
    8'd1,   8'd3,   8'd11,  8'd22,  8'd38,  8'd57,  8'd79,  8'd103
  };

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

endpackage

// File: rtl/bpsk_sine_rom.sv
// Combinational carrier ROM: phase index and polarity in, offset-binary sample out.
module bpsk_sine_rom
  import bpsk_pkg::*;
(
  input  logic [PHASE_W-1:0] phase,
  input  logic               polarity,
  output logic [7:0]         sample
);

  // Negative polarity is 256 - S, which in 8 bits is the two's complement of S.
  always_comb begin
    if (polarity) sample = SINE_LUT[phase];
    else          sample = ~SINE_LUT[phase] + 8'd1;
  end

endmodule

// File: rtl/bpsk_sample_gen.sv
// BPSK sample generator: serialises bytes MSB-first into whole carrier periods
// of sine, polarity set per bit, as an 8-bit offset-binary sample stream.
// Optional macro BPSK_DIFF_ENC_EN selects differential encoding.
module bpsk_sample_gen
  import bpsk_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 16,
  parameter int unsigned CYCLES_PER_BIT = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] In_Data,
  input  logic       In_Valid,
  output logic       In_Ready,
  output logic [7:0] Sample,
  output logic       Sample_Strobe,
  output logic       Busy
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(LUT_DEPTH - 1);

  state_t             state, state_d;
  logic [DIV_W-1:0]   div, div_d;
  logic [PHASE_W-1:0] phase, phase_d;
  logic [CYC_W-1:0]   cyc, cyc_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shreg, shreg_d;
  logic [7:0]         sample_d;
  logic               strobe_d;

  logic tick, period_end, last_edge, accept, go_idle;
  logic bit_start, start_bit, start_pol, cur_pol;
  logic [PHASE_W-1:0] rom_phase;
  logic               rom_pol;
  logic [7:0]         rom_sample;

  bpsk_sine_rom u_rom (
    .phase    (rom_phase),
    .polarity (rom_pol),
    .sample   (rom_sample)
  );

  assign Busy = (state == SEND);

  // Decode sample strobe, period/bit boundaries and the handshake.
  always_comb begin
    tick       = (state == SEND) && (div == DIV_LAST);
    period_end = tick && (phase == PHASE_LAST);
    last_edge  = period_end && (cyc == CYC_LAST) && (bit_idx == 3'd0);
    In_Ready   = (state == IDLE) || last_edge;
    accept     = In_Valid && In_Ready;
    go_idle    = last_edge && !In_Valid;
    bit_start  = accept || (period_end && (cyc == CYC_LAST) && !last_edge);
    start_bit  = accept ? In_Data[7] : shreg[6];
  end

`ifdef BPSK_DIFF_ENC_EN
  logic ref_q;

  // Differential reference: toggles on each 1 bit, polarity follows it.
  always_comb begin
    start_pol = ref_q ^ start_bit;
    cur_pol   = ref_q;
  end

  // Reference register, cleared on return to idle only.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)       ref_q <= 1'b0;
    else if (go_idle)   ref_q <= 1'b0;
    else if (bit_start) ref_q <= start_pol;
  end
`else
  // Absolute BPSK: polarity is the bit itself.
  always_comb begin
    start_pol = start_bit;
    cur_pol   = shreg[7];
  end
`endif

  // Next-state, counter and sample computation.
  always_comb begin
    state_d   = state;
    div_d     = div;
    phase_d   = phase;
    cyc_d     = cyc;
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    sample_d  = Sample;
    strobe_d  = 1'b0;
    rom_phase = phase;
    rom_pol   = cur_pol;
    if (accept) begin
      // Covers both a fresh start from idle and a back-to-back reload.
      state_d   = SEND;
      div_d     = '0;
      phase_d   = '0;
      cyc_d     = '0;
      bit_idx_d = 3'd7;
      shreg_d   = In_Data;
      rom_phase = '0;
      rom_pol   = start_pol;
      sample_d  = rom_sample;
      strobe_d  = 1'b1;
    end else if (last_edge) begin
      state_d   = IDLE;
      div_d     = '0;
      phase_d   = '0;
      cyc_d     = '0;
      bit_idx_d = '0;
      shreg_d   = '0;
      sample_d  = IDLE_LEVEL;
      strobe_d  = 1'b1;
    end else if (tick) begin
      div_d   = '0;
      phase_d = phase + 1'b1;
      if (period_end) begin
        if (cyc == CYC_LAST) begin
          cyc_d     = '0;
          bit_idx_d = bit_idx - 3'd1;
          shreg_d   = {shreg[6:0], 1'b0};
        end else begin
          cyc_d = cyc + 1'b1;
        end
      end
      rom_phase = phase_d;
      rom_pol   = bit_start ? start_pol : cur_pol;
      sample_d  = rom_sample;
      strobe_d  = 1'b1;
    end else if (state == SEND) begin
      div_d = div + 1'b1;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      div           <= '0;
      phase         <= '0;
      cyc           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      Sample        <= IDLE_LEVEL;
      Sample_Strobe <= 1'b0;
    end else begin
      state         <= state_d;
      div           <= div_d;
      phase         <= phase_d;
      cyc           <= cyc_d;
      bit_idx       <= bit_idx_d;
      shreg         <= shreg_d;
      Sample        <= sample_d;
      Sample_Strobe <= strobe_d;
    end
  end

endmodule

// File: tb/tb_bpsk_sample_gen.sv
// Scoreboard bench for bpsk_sample_gen (SAMPLE_DIV=2, CYCLES_PER_BIT=1).
`timescale 1ns/1ps
module tb_bpsk_sample_gen;

  localparam int unsigned SD  = 2;
  localparam int unsigned CPB = 1;

  logic       Clk = 1'b0;
  logic       rst_n;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Ready;
  logic [7:0] Sample;
  logic       Sample_Strobe;
  logic       Busy;

  int checks   = 0;
  int errors   = 0;
  int busy_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  int sine [32] = '{128, 153, 177, 199, 218, 234, 245, 253,
                    255, 253, 245, 234, 218, 199, 177, 153,
                    128, 103, 79,  57,  38,  22,  11,  3,
                    1,   3,   11,  22,  38,  57,  79,  103};

  always #5 Clk = ~Clk;

  bpsk_sample_gen #(.SAMPLE_DIV(SD), .CYCLES_PER_BIT(CPB)) dut (
    .Clk           (Clk),
    .Reset_n       (rst_n),
    .In_Data       (In_Data),
    .In_Valid      (In_Valid),
    .In_Ready      (In_Ready),
    .Sample        (Sample),
    .Sample_Strobe (Sample_Strobe),
    .Busy          (Busy)
  );

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got=%0d required=%0d", name, got, req);
    end
  endtask

  // Monitor: every strobe pops one expected sample; also counts busy cycles.
  always @(negedge Clk) begin
    if (rst_n === 1'b1) begin
      if (Busy) busy_cnt++;
      if (Sample_Strobe) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got=%0d required=no strobe", Sample);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sample", int'(Sample), int'(mon_exp));
        end
      end
    end
  end

  // Expected stream for a burst of n back-to-back bytes followed by idle.
  task automatic push_burst(input logic [7:0] b0, input logic [7:0] b1, input int n);
    logic       r;
    logic       p;
    logic [7:0] byt;
    r = 1'b0;
    for (int j = 0; j < n; j++) begin
      byt = (j == 0) ? b0 : b1;
      for (int i = 7; i >= 0; i--) begin
`ifdef BPSK_DIFF_ENC_EN
        r = r ^ byt[i];
        p = r;
`else
        p = byt[i];
`endif
        for (int c = 0; c < int'(CPB); c++)
          for (int k = 0; k < 32; k++)
            exp_q.push_back(p ? 8'(sine[k]) : 8'(256 - sine[k]));
      end
    end
    exp_q.push_back(8'd128);
  endtask

  // Waits (bounded) for In_Ready, then consumes the accepting edge.
  task automatic wait_accept(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (In_Ready) break;
      @(negedge Clk);
    end
    check(name, int'(i < 3000), 1);
    if (i < 3000) @(posedge Clk);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 5000; i++) begin
      if (!Busy) break;
      @(negedge Clk);
    end
    check("busy_end", int'(i < 5000), 1);
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input int n, input int exp_busy);
    busy_cnt = 0;
    push_burst(b0, b1, n);
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data  = b0;
    wait_accept("accept_first");
    @(negedge Clk);
    check("strobe_after_accept", int'(Sample_Strobe), 1);
    check("first_sample", int'(Sample), 128);
    if (n == 2) begin
      In_Data = b1;
      wait_accept("accept_second");
      @(negedge Clk);
    end
    In_Valid = 1'b0;
    In_Data  = 8'h3C;
    wait_idle();
    repeat (2) @(negedge Clk);
    check("busy_cycles", busy_cnt, exp_busy);
    check("queue_drained", exp_q.size(), 0);
    check("idle_sample", int'(Sample), 128);
    check("idle_ready", int'(In_Ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    In_Valid = 1'b0;
    In_Data  = 8'h00;
    repeat (5) @(negedge Clk);
    check("reset_sample", int'(Sample), 128);
    check("reset_busy", int'(Busy), 0);
    check("reset_strobe", int'(Sample_Strobe), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      check("idle_hold", int'({Sample, Busy, In_Ready, Sample_Strobe}), int'({8'd128, 1'b0, 1'b1, 1'b0}));
    end

    send(8'hFF, 8'h00, 1, 512);
    send(8'h00, 8'h00, 1, 512);
    send(8'hA5, 8'h5A, 2, 1024);
    send(8'hC0, 8'h00, 1, 512);
    send(8'h80, 8'h00, 1, 512);
    send(8'h40, 8'h00, 1, 512);

    // Abort mid-byte around bit 3, k=12.
    push_burst(8'hB3, 8'h00, 1);
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data  = 8'hB3;
    wait_accept("accept_abort");
    @(negedge Clk);
    In_Valid = 1'b0;
    repeat (279) @(posedge Clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sample", int'(Sample), 128);
    check("abort_busy", int'(Busy), 0);
    check("abort_strobe", int'(Sample_Strobe), 0);
    exp_q.delete();
    repeat (3) @(negedge Clk);
    rst_n = 1'b1;
    send(8'h80, 8'h00, 1, 512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
